// File: rtl/axilite_pkg.sv
// rtl/axilite_pkg.sv - shared AXI4-lite response codes, FSM state types and byte-merge helper
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ADDR_LSB    = 2;

  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_data;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axilite_reg_slave_if.sv
// rtl/axilite_reg_slave_if.sv - AXI4-lite bus bundle with master/slave views
interface axilite_reg_slave_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axilite_reg_bank.sv
// rtl/axilite_reg_bank.sv - register storage with byte-merge write port and read mux
module axilite_reg_bank import axilite_pkg::*; #(
  parameter int          NUM_REGS    = 16,
  parameter logic [63:0] RO_MASK     = 64'h0,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W-1:0]       widx,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic [IDX_W-1:0]       ridx,
  output logic [31:0]            rdata,
  output logic [32*NUM_REGS-1:0] reg_ctrl,
  input  logic [32*NUM_REGS-1:0] reg_status
);

  logic [31:0] regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      // Read-only slots hold no state; their control output stays at the reset value.
      assign regs[i] = RESET_VALUE;
    end else begin : g_rw
      logic [31:0] q;
      // Commit a byte-merged write when this slot is addressed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= RESET_VALUE;
        end else if (we && widx == IDX_W'(i)) begin
          q <= wstrb_merge(q, wdata, wstrb);
        end
      end
      assign regs[i] = q;
    end
    assign reg_ctrl[32*i +: 32] = regs[i];
  end

  // Read mux: RO slots return the live status input, RW slots the stored value.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) rdata = RO_MASK[i] ? reg_status[32*i +: 32] : regs[i];
    end
  end

endmodule

// File: rtl/axilite_reg_slave.sv
// rtl/axilite_reg_slave.sv - AXI4-lite register endpoint: write/read FSMs, holding regs, decode
module axilite_reg_slave import axilite_pkg::*; #(
  parameter int          NUM_REGS    = 16,
  parameter logic [63:0] RO_MASK     = 64'h0,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  axilite_reg_slave_if.slave     s_axi,
  output logic [32*NUM_REGS-1:0] reg_ctrl_o,
  input  logic [32*NUM_REGS-1:0] reg_status_i,
  output logic [NUM_REGS-1:0]    reg_wr_pulse_o
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int UP_LSB = ADDR_LSB + IDX_W;

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic        aw_held, w_held;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] bank_rdata;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        commit, wr_err, rd_err, bank_we;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Address is bad if the index is past the last register or any bit above the index is set.
  function automatic logic addr_bad(input logic [31:ADDR_LSB] a);
    return (|a[31:UP_LSB]) || (32'(a[ADDR_LSB +: IDX_W]) >= 32'(NUM_REGS));
  endfunction

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign b_hs  = s_axi.bvalid  && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid  && s_axi.rready;

  assign commit  = (wr_state == W_IDLE) && aw_held && w_held;
  assign wr_idx  = aw_addr_q[ADDR_LSB +: IDX_W];
  assign rd_idx  = s_axi.araddr[ADDR_LSB +: IDX_W];
  assign wr_err  = addr_bad(aw_addr_q[31:ADDR_LSB]) || RO_MASK[wr_idx];
  assign rd_err  = addr_bad(s_axi.araddr[31:ADDR_LSB]);
  assign bank_we = commit && !wr_err;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, aw_addr_q[1:0], s_axi.araddr[1:0]};

  axilite_reg_bank #(
    .NUM_REGS    (NUM_REGS),
    .RO_MASK     (RO_MASK),
    .RESET_VALUE (RESET_VALUE),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .we         (bank_we),
    .widx       (wr_idx),
    .wdata      (w_data_q),
    .wstrb      (w_strb_q),
    .ridx       (rd_idx),
    .rdata      (bank_rdata),
    .reg_ctrl   (reg_ctrl_o),
    .reg_status (reg_status_i)
  );

  // AW and W are captured independently; both holds clear together on the commit edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
    end
  end

  // Write response code and per-register commit strobe, registered on the commit edge.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      bresp_q        <= RESP_OKAY;
      reg_wr_pulse_o <= '0;
    end else begin
      if (commit) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse_o[i] <= bank_we && (wr_idx == IDX_W'(i));
      end
    end
  end

  // Read data and response are sampled once at the AR handshake and held until R completes.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_err ? '0 : bank_rdata;
      rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // State registers for both FSMs.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Next-state logic: write leaves IDLE on commit, read on AR; each returns on its handshake.
  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    case (wr_state)
      W_IDLE:  if (commit) wr_next = W_RESP;
      W_RESP:  if (b_hs)   wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (r_hs)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Outputs come from registered state only, so no input reaches a ready or valid combinationally.
  always_comb begin
    s_axi.awready = (wr_state == W_IDLE) && !aw_held;
    s_axi.wready  = (wr_state == W_IDLE) && !w_held;
    s_axi.bvalid  = (wr_state == W_RESP);
    s_axi.bresp   = bresp_q;
    s_axi.arready = (rd_state == R_IDLE);
    s_axi.rvalid  = (rd_state == R_DATA);
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
  end

endmodule

// File: tb/tb_axilite_reg_slave.sv
// tb/tb_axilite_reg_slave.sv - directed self-checking bench for axilite_reg_slave
module tb_axilite_reg_slave;

  localparam int NUM_REGS = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axilite_reg_slave_if bus();

  logic [32*NUM_REGS-1:0] reg_ctrl;
  logic [32*NUM_REGS-1:0] reg_status;
  logic [NUM_REGS-1:0]    pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_total = 0;

  axilite_reg_slave #(
    .NUM_REGS    (NUM_REGS),
    .RO_MASK     (64'h8),
    .RESET_VALUE (32'h0)
  ) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .s_axi          (bus),
    .reg_ctrl_o     (reg_ctrl),
    .reg_status_i   (reg_status),
    .reg_wr_pulse_o (pulse)
  );

  always @(posedge clk) pulse_total = pulse_total + $countones(pulse);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl(input int i);
    return reg_ctrl[32*i +: 32];
  endfunction

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_done, w_done, aw_fire, w_fire;
    aw_done = 1'b0;
    w_done  = 1'b0;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_fire) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("aw_w_accept", {62'b0, aw_done, w_done}, 64'h3);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    for (int n = 0; n < 20 && !bus.bvalid; n++) @(negedge clk);
    check("b_timeout", bus.bvalid, 1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    send_aw_w(addr, data, strb);
    wait_b(resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic done, fire;
    done = 1'b0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      fire = bus.arvalid && bus.arready;
      @(negedge clk);
      if (fire) begin done = 1'b1; bus.arvalid = 1'b0; end
    end
    bus.arvalid = 1'b0;
    for (int n = 0; n < 20 && !bus.rvalid; n++) @(negedge clk);
    check("r_timeout", bus.rvalid, 1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic idle_bus();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          p0;
    logic        stable;

    idle_bus();
    reg_status = '0;
    reg_status[32*3 +: 32] = 32'hCAFE0001;
    reg_status[32*2 +: 32] = 32'h55555555;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_pulse", pulse, 0);
    check("rst_ctrl_any", {63'b0, |reg_ctrl}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: AW and W in the same cycle; response two edges after the handshake edge
    bus.awaddr = 32'h08; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("t1_bvalid_early", bus.bvalid, 0);
    check("t1_readys_low", {62'b0, bus.awready, bus.wready}, 0);
    @(negedge clk);
    check("t1_bvalid", bus.bvalid, 1);
    check("t1_bresp", bus.bresp, 2'b00);
    check("t1_reg2", ctrl(2), 32'hDEADBEEF);
    check("t1_pulse", pulse, 16'h0004);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t1_bvalid_drop", bus.bvalid, 0);
    check("t1_awready_back", bus.awready, 1);
    do_read(32'h08, data, resp);
    check("t1_rdata", data, 32'hDEADBEEF);
    check("t1_rresp", resp, 2'b00);

    // 2: W three cycles ahead of AW, partial strobes
    p0 = pulse_total;
    bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("t2_wready_held", bus.wready, 0);
    check("t2_awready_open", bus.awready, 1);
    repeat (2) @(negedge clk);
    check("t2_no_b_yet", bus.bvalid, 0);
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    wait_b(resp);
    check("t2_bresp", resp, 2'b00);
    check("t2_reg1", ctrl(1), 32'h00220044);
    check("t2_pulses", pulse_total - p0, 1);

    // 3: out-of-range / upper address bits
    do_read(32'h40, data, resp);
    check("t3_rresp", resp, 2'b10);
    check("t3_rdata", data, 0);
    p0 = pulse_total;
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, resp);
    check("t3_bresp", resp, 2'b10);
    do_write(32'h1000_0008, 32'hFFFFFFFF, 4'hF, resp);
    check("t3_upper_bresp", resp, 2'b10);
    check("t3_no_pulse", pulse_total - p0, 0);
    check("t3_reg0", ctrl(0), 0);
    check("t3_reg2", ctrl(2), 32'hDEADBEEF);

    // 4: read-only register
    do_read(32'h0C, data, resp);
    check("t4_ro_rdata", data, 32'hCAFE0001);
    check("t4_ro_rresp", resp, 2'b00);
    p0 = pulse_total;
    do_write(32'h0C, 32'h12345678, 4'hF, resp);
    check("t4_ro_bresp", resp, 2'b10);
    check("t4_ro_no_pulse", pulse_total - p0, 0);

    // byte merge and zero strobe on a RW register
    do_write(32'h08, 32'hA5A5A5A5, 4'b1000, resp);
    check("bm_reg2", ctrl(2), 32'hA5ADBEEF);
    p0 = pulse_total;
    do_write(32'h08, 32'h00000000, 4'b0000, resp);
    check("bm_zero_resp", resp, 2'b00);
    check("bm_zero_reg2", ctrl(2), 32'hA5ADBEEF);
    check("bm_zero_pulse", pulse_total - p0, 1);

    // 5: back-pressure on B and R
    send_aw_w(32'h10, 32'h12345678, 4'hF);
    for (int n = 0; n < 20 && !bus.bvalid; n++) @(negedge clk);
    bus.awaddr = 32'h18; bus.awvalid = 1'b1;
    stable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (!bus.bvalid || bus.bresp != 2'b00 || bus.awready || bus.wready) stable = 1'b0;
      @(negedge clk);
    end
    check("t5_b_stall", stable, 1);
    bus.awvalid = 1'b0;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t5_reg4", ctrl(4), 32'h12345678);
    bus.araddr = 32'h04; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.araddr = 32'h08;
    stable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (!bus.rvalid || bus.rdata != 32'h00220044 || bus.rresp != 2'b00 || bus.arready) stable = 1'b0;
      @(negedge clk);
    end
    check("t5_r_stall", stable, 1);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("t5_rvalid_drop", bus.rvalid, 0);
    check("t5_arready_back", bus.arready, 1);

    // read and write commit on the same edge to the same register: read sees the old value
    bus.awaddr = 32'h10; bus.awvalid = 1'b1;
    bus.wdata = 32'h9ABCDEF0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h10; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rw_same_rdata", bus.rdata, 32'h12345678);
    check("rw_same_reg4", ctrl(4), 32'h9ABCDEF0);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;

    // 6: reset with a write response and a read pending
    send_aw_w(32'h14, 32'h0F0F0F0F, 4'hF);
    for (int n = 0; n < 20 && !bus.bvalid; n++) @(negedge clk);
    bus.araddr = 32'h08; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("t6_pre_bvalid", bus.bvalid, 1);
    check("t6_pre_rvalid", bus.rvalid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_bvalid", bus.bvalid, 0);
    check("t6_rvalid", bus.rvalid, 0);
    check("t6_readys", {61'b0, bus.awready, bus.wready, bus.arready}, 64'h7);
    check("t6_ctrl", {63'b0, |reg_ctrl}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_bvalid", bus.bvalid, 0);
    do_read(32'h08, data, resp);
    check("t6_post_rdata", data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
